// File: rtl/fg_pkg.sv
// Shared definitions for the waveform generator output stage: FSM encoding,
// default DAC command prefix and SPI idle levels.
package fg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_DAC_CMD = 4'b0011;

    localparam logic SCLK_IDLE = 1'b0;
    localparam logic CS_IDLE   = 1'b1;

endpackage

// File: rtl/fg_out_scale.sv
// Combinational offset add, clamp to the unsigned DAC range and truncation
// to the DAC code width.
module fg_out_scale #(
    parameter int WAVEFORM_BITWIDTH = 16,
    parameter int DAC_BITWIDTH      = 12
) (
    input  logic signed [WAVEFORM_BITWIDTH:0] i_sample,
    input  logic signed [WAVEFORM_BITWIDTH:0] i_offset,
    output logic [DAC_BITWIDTH-1:0]           o_code
);

    localparam int W = WAVEFORM_BITWIDTH;

    logic signed [W+1:0] w_sum;
    logic [W-1:0]        w_clamped;

    assign w_sum = {i_sample[W], i_sample} + {i_offset[W], i_offset};

    // Bit W+1 is the sign; with both operands in range a non-negative sum
    // can only exceed 2^W-1 by setting bit W.
    always_comb begin
        if (w_sum[W+1]) begin
            w_clamped = '0;
        end else if (w_sum[W]) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_sum[W-1:0];
        end
    end

    assign o_code = w_clamped[W-1 -: DAC_BITWIDTH];

    generate
        if (DAC_BITWIDTH < WAVEFORM_BITWIDTH) begin : g_drop_lsbs
            logic w_unused_lsbs;
            assign w_unused_lsbs = ^w_clamped[W-DAC_BITWIDTH-1:0];
        end
    endgenerate

endmodule

// File: rtl/fg_dac_spi_out.sv
// Converts waveform samples to DAC codes and shifts {cmd, code} frames out to
// an SPI DAC (mode 0, MSB first) with a one-deep pending sample register.
module fg_dac_spi_out
    import fg_pkg::*;
#(
    parameter int                  WAVEFORM_BITWIDTH = 16,
    parameter int                  DAC_BITWIDTH      = 12,
    parameter int                  CMD_BITS          = 4,
    parameter logic [CMD_BITS-1:0] DAC_CMD           = CMD_BITS'(DEFAULT_DAC_CMD),
    parameter int                  SCLK_DIV          = 2
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           enable_i,
    input  logic                           sample_valid_i,
    input  logic signed [WAVEFORM_BITWIDTH:0] sample_i,
    input  logic signed [WAVEFORM_BITWIDTH:0] offset_i,
    output logic                           sclk_o,
    output logic                           mosi_o,
    output logic                           cs_n_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    localparam int N     = CMD_BITS + DAC_BITWIDTH;
    localparam int CNT_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = (N > 1) ? $clog2(N) : 1;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_div_cnt, w_div_cnt_nxt;
    logic [BIT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [N-1:0]       r_shift, w_shift_nxt;
    logic               r_sclk, w_sclk_nxt;
    logic               r_cs_n, w_cs_n_nxt;
    logic               r_pend_valid, w_pend_valid_nxt;
    logic [N-1:0]       r_pend_frame, w_pend_frame_nxt;
    logic               r_overrun, w_overrun_nxt;

    logic [DAC_BITWIDTH-1:0] w_code;
    logic [N-1:0]            w_frame;
    logic                    w_div_done;
    logic                    w_take;
    logic                    w_hold_end;

    fg_out_scale #(
        .WAVEFORM_BITWIDTH (WAVEFORM_BITWIDTH),
        .DAC_BITWIDTH      (DAC_BITWIDTH)
    ) u_scale (
        .i_sample (sample_i),
        .i_offset (offset_i),
        .o_code   (w_code)
    );

    assign w_frame    = {DAC_CMD, w_code};
    assign w_div_done = (r_div_cnt == CNT_W'(SCLK_DIV - 1));
    assign w_take     = sample_valid_i && enable_i;
    assign w_hold_end = (r_state == ST_HOLD) && w_div_done;

    always_comb begin
        // NOTE: every next value gets a default first so no path through this
        // block leaves a signal unassigned and infers a latch.
        w_state_nxt      = r_state;
        w_div_cnt_nxt    = w_div_done ? '0 : r_div_cnt + 1'b1;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_sclk_nxt       = r_sclk;
        w_cs_n_nxt       = r_cs_n;
        w_pend_valid_nxt = enable_i ? r_pend_valid : 1'b0;
        w_pend_frame_nxt = r_pend_frame;
        w_overrun_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_div_cnt_nxt = '0;
                if (w_take) begin
                    w_state_nxt = ST_SETUP;
                    w_shift_nxt = w_frame;
                    w_cs_n_nxt  = 1'b0;
                end
            end
            ST_SETUP: begin
                if (w_div_done) begin
                    w_state_nxt   = ST_SHIFT;
                    w_sclk_nxt    = 1'b1;
                    w_bit_cnt_nxt = '0;
                end
            end
            ST_SHIFT: begin
                if (w_div_done) begin
                    if (r_sclk) begin
                        w_sclk_nxt  = 1'b0;
                        w_shift_nxt = {r_shift[N-2:0], 1'b0};
                    end else if (r_bit_cnt == BIT_W'(N - 1)) begin
                        w_state_nxt = ST_HOLD;
                        w_cs_n_nxt  = 1'b1;
                    end else begin
                        w_sclk_nxt    = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (w_div_done) begin
                    if (w_take) begin
                        // A strobe on the last HOLD cycle beats the pending sample.
                        w_state_nxt      = ST_SETUP;
                        w_shift_nxt      = w_frame;
                        w_cs_n_nxt       = 1'b0;
                        w_overrun_nxt    = r_pend_valid;
                        w_pend_valid_nxt = 1'b0;
                    end else if (r_pend_valid && enable_i) begin
                        w_state_nxt      = ST_SETUP;
                        w_shift_nxt      = r_pend_frame;
                        w_cs_n_nxt       = 1'b0;
                        w_pend_valid_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if ((r_state != ST_IDLE) && w_take && !w_hold_end) begin
            w_pend_frame_nxt = w_frame;
            w_pend_valid_nxt = 1'b1;
            w_overrun_nxt    = r_pend_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before this edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_sclk       <= SCLK_IDLE;
            r_cs_n       <= CS_IDLE;
            r_pend_valid <= 1'b0;
            r_pend_frame <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_div_cnt    <= w_div_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_sclk       <= w_sclk_nxt;
            r_cs_n       <= w_cs_n_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_frame <= w_pend_frame_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign sclk_o    = r_sclk;
    assign mosi_o    = r_shift[N-1];
    assign cs_n_o    = r_cs_n;
    assign busy_o    = (r_state != ST_IDLE);
    assign overrun_o = r_overrun;

endmodule
